// File: rtl/axi_b_pkg.sv
// rtl/axi_b_pkg.sv - shared AXI B-channel widths, BRESP codes and output-register state
`ifndef AXI_MASTER_BITS
`define AXI_MASTER_BITS 2
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS (`AXI_MASTER_BITS + `AXI_ID_BITS)
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

package axi_b_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } bresp_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter, search starts one past the last grant
module rr_arb #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW-1:0] ptr_q;
  logic          found;

  always_comb begin
    int c;
    c       = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= N; i++) begin
      c = int'(ptr_q) + i;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt_idx = IW'(c);
      end
    end
  end

  assign gnt_vld = found && en;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) gnt[i] = gnt_vld && (gnt_idx == IW'(i));
  end

  // Pointer moves only on an actual grant so an idle cycle keeps fairness state.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(N - 1);
    else if (gnt_vld) ptr_q <= gnt_idx;
  end

endmodule

// File: rtl/b_ch_rr.sv
// rtl/b_ch_rr.sv - write-response (B) channel N:M round-robin mux, one-entry output register
// Optional saturating error counter enabled by macro B_CH_ERRCNT_EN.
module b_ch_rr
  import axi_b_pkg::*;
#(
  parameter int NUM_SLAVES  = 3,
  parameter int NUM_MASTERS = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_SLAVES-1:0][`AXI_IDS_BITS-1:0]    ids_s_i,
  input  logic [NUM_SLAVES-1:0][`AXI_RESP_BITS-1:0]   resp_s_i,
  input  logic [NUM_SLAVES-1:0]                       valid_s_i,
  output logic [NUM_SLAVES-1:0]                       ready_s_o,
  output logic [`AXI_ID_BITS-1:0]                     id_m_o,
  output logic [`AXI_RESP_BITS-1:0]                   resp_m_o,
  output logic [NUM_MASTERS-1:0]                      valid_m_o,
  input  logic [NUM_MASTERS-1:0]                      ready_m_i,
  output logic [7:0]                                  err_cnt_o
);

  localparam int MB = `AXI_MASTER_BITS;
  localparam int IB = `AXI_ID_BITS;
  localparam int XB = `AXI_IDS_BITS;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_e                     state_q;
  logic [MB-1:0]              master_q;
  logic [IB-1:0]              id_q;
  logic [`AXI_RESP_BITS-1:0]  resp_q;

  logic                       master_rdy;
  logic                       free;
  logic                       arb_en;
  logic [SW-1:0]              gnt_idx;
  logic                       gnt_vld;
  logic [XB-1:0]              sel_ids;
  logic [MB-1:0]              sel_master;
  logic [`AXI_RESP_BITS-1:0]  sel_resp;
  logic                       sel_ok;
  logic [NUM_MASTERS-1:0]     sel_onehot;

  always_comb begin
    master_rdy = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++)
      if (master_q == MB'(m)) master_rdy = ready_m_i[m];
  end

  assign free   = (state_q == ST_EMPTY) || master_rdy;
  assign arb_en = free && !rst;

  rr_arb #(.N(NUM_SLAVES), .IW(SW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (valid_s_i),
    .en      (arb_en),
    .gnt     (ready_s_o),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign sel_ids    = ids_s_i[gnt_idx];
  assign sel_master = sel_ids[XB-1 -: MB];
  assign sel_resp   = resp_s_i[gnt_idx];
  // Responses routed to a nonexistent master are acknowledged but dropped.
  assign sel_ok     = int'(sel_master) < NUM_MASTERS;

  always_comb begin
    sel_onehot = '0;
    for (int m = 0; m < NUM_MASTERS; m++) sel_onehot[m] = (sel_master == MB'(m));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      master_q  <= '0;
      id_q      <= '0;
      resp_q    <= '0;
      valid_m_o <= '0;
    end else if (free) begin
      if (gnt_vld && sel_ok) begin
        state_q   <= ST_FULL;
        master_q  <= sel_master;
        id_q      <= sel_ids[IB-1:0];
        resp_q    <= sel_resp;
        valid_m_o <= sel_onehot;
      end else begin
        state_q   <= ST_EMPTY;
        master_q  <= '0;
        id_q      <= '0;
        resp_q    <= '0;
        valid_m_o <= '0;
      end
    end
  end

  assign id_m_o   = id_q;
  assign resp_m_o = resp_q;

`ifdef B_CH_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else if (gnt_vld && (sel_resp != RESP_OKAY) && (err_q != 8'hff)) err_q <= err_q + 8'd1;
  end

  assign err_cnt_o = err_q;
`else
  assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_b_ch_rr.sv
// tb/tb_b_ch_rr.sv - directed self-checking bench for b_ch_rr (default and B_CH_ERRCNT_EN builds)
`ifndef AXI_MASTER_BITS
`define AXI_MASTER_BITS 2
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS (`AXI_MASTER_BITS + `AXI_ID_BITS)
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

module tb_b_ch_rr;

  logic                                  clk = 1'b0;
  logic                                  rst;
  logic [2:0][`AXI_IDS_BITS-1:0]         ids;
  logic [2:0][`AXI_RESP_BITS-1:0]        resps;
  logic [2:0]                            valid_s;
  logic [2:0]                            ready_s;
  logic [`AXI_ID_BITS-1:0]               id_m;
  logic [`AXI_RESP_BITS-1:0]             resp_m;
  logic [1:0]                            valid_m;
  logic [1:0]                            ready_m;
  logic [7:0]                            err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  b_ch_rr #(.NUM_SLAVES(3), .NUM_MASTERS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ids_s_i   (ids),
    .resp_s_i  (resps),
    .valid_s_i (valid_s),
    .ready_s_o (ready_s),
    .id_m_o    (id_m),
    .resp_m_o  (resp_m),
    .valid_m_o (valid_m),
    .ready_m_i (ready_m),
    .err_cnt_o (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_slv [6];
    logic [7:0] exp_err;
    exp_slv = '{2, 0, 1, 2, 0, 1};

    rst = 1'b1; ids = '0; resps = '0; valid_s = 3'b111; ready_m = 2'b00;
    step();
    step();
    check("rst_ready_s", 32'(ready_s), 32'h0);
    check("rst_valid_m", 32'(valid_m), 32'h0);
    check("rst_id_m", 32'(id_m), 32'h0);
    check("rst_resp_m", 32'(resp_m), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    rst = 1'b0; valid_s = 3'b000;
    step();

    // single response slave1 -> master 1; pointer was 2 so slave1 wins against nobody
    ids[1] = 6'h13; resps[1] = 2'b00; valid_s = 3'b010; ready_m = 2'b10;
    #1 check("single_ready_s", 32'(ready_s), 32'h2);
    step();
    valid_s = 3'b000;
    #1;
    check("single_valid_m", 32'(valid_m), 32'h2);
    check("single_id_m", 32'(id_m), 32'h3);
    check("single_resp_m", 32'(resp_m), 32'h0);
    step();
    check("single_drain", 32'(valid_m), 32'h0);
    check("empty_id_zero", 32'(id_m), 32'h0);

    // continuous round robin, pointer now 1 -> 2,0,1,2,0,1
    ids = {6'h03, 6'h02, 6'h01}; resps = '0; valid_s = 3'b111; ready_m = 2'b01;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("rr_grant", 32'(ready_s), 32'(1) << exp_slv[k]);
      if (k > 0) begin
        check("rr_valid_m", 32'(valid_m), 32'h1);
        check("rr_id_m", 32'(id_m), 32'(exp_slv[k-1] + 1));
      end
      step();
    end
    check("rr_last_id", 32'(id_m), 32'h2);
    valid_s = 3'b000;
    step();
    check("rr_drain", 32'(valid_m), 32'h0);

    // stall: FULL to master1 with ready low for 5 cycles
    ids[0] = 6'h15; resps = {2'b00, 2'b00, 2'b01}; valid_s = 3'b001; ready_m = 2'b00;
    #1 check("stall_first_grant", 32'(ready_s), 32'h1);
    step();
    valid_s = 3'b111;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("stall_ready_s", 32'(ready_s), 32'h0);
      check("stall_valid_m", 32'(valid_m), 32'h2);
      check("stall_id_m", 32'(id_m), 32'h5);
      check("stall_resp_m", 32'(resp_m), 32'h1);
      step();
    end
    ready_m = 2'b10;
    #1 check("stall_resume_grant", 32'(ready_s), 32'h2);
    step();
    valid_s = 3'b000; ready_m = 2'b01;
    #1;
    check("stall_next_valid_m", 32'(valid_m), 32'h1);
    check("stall_next_id_m", 32'(id_m), 32'h2);
    step();

    // master field 3 with two masters: accepted and dropped
    ids[2] = 6'h37; resps[2] = 2'b10; valid_s = 3'b100; ready_m = 2'b11;
    #1 check("discard_ready_s", 32'(ready_s), 32'h4);
    step();
    valid_s = 3'b000;
    #1;
    check("discard_valid_m", 32'(valid_m), 32'h0);
    check("discard_id_m", 32'(id_m), 32'h0);
`ifdef B_CH_ERRCNT_EN
    exp_err = 8'd2;
`else
    exp_err = 8'd0;
`endif
    check("err_mid", 32'(err_cnt), 32'(exp_err));

    // reset while FULL
    ids[0] = 6'h19; resps[0] = 2'b00; valid_s = 3'b001; ready_m = 2'b00;
    step();
    valid_s = 3'b000;
    #1;
    check("pre_rst_valid_m", 32'(valid_m), 32'h2);
    check("pre_rst_id_m", 32'(id_m), 32'h9);
    rst = 1'b1; valid_s = 3'b111;
    #1 check("in_rst_ready_s", 32'(ready_s), 32'h0);
    step();
    check("post_rst_valid_m", 32'(valid_m), 32'h0);
    check("post_rst_id_m", 32'(id_m), 32'h0);
    check("post_rst_resp_m", 32'(resp_m), 32'h0);
    check("post_rst_err", 32'(err_cnt), 32'h0);
    rst = 1'b0; ids = {6'h03, 6'h02, 6'h01}; resps = '0; ready_m = 2'b01;
    #1 check("post_rst_slave0_first", 32'(ready_s), 32'h1);
    step();
    valid_s = 3'b000;
    #1;
    check("post_rst_load_valid", 32'(valid_m), 32'h1);
    check("post_rst_load_id", 32'(id_m), 32'h1);
    step();

    // 300 SLVERR responses back to back
    ids[0] = 6'h01; resps[0] = 2'b10; valid_s = 3'b001; ready_m = 2'b01;
    #1;
    for (int k = 0; k < 300; k++) begin
      check("slverr_stream_grant", 32'(ready_s), 32'h1);
      step();
    end
    valid_s = 3'b000;
    step();
`ifdef B_CH_ERRCNT_EN
    exp_err = 8'd255;
`else
    exp_err = 8'd0;
`endif
    check("err_saturate", 32'(err_cnt), 32'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
